// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// Used by the loader top, its word assembler and the bus interface.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RECV  = 3'd1,
        WRITE = 3'd2,
        DONE  = 3'd3,
        ERR   = 3'd4
    } state_e;

    localparam int BYTES_PER_WORD = 4;
    localparam int WORD_W         = 32;
    localparam int BYTE_W         = 8;

    // Running XOR signature of the words written by one load
    function automatic logic [WORD_W-1:0] checksum_fold(
        input logic [WORD_W-1:0] acc,
        input logic [WORD_W-1:0] word
    );
        return acc ^ word;
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Program-source / instruction-memory / pipeline-control bundle of the loader.
// The slave side is the loader; the master side is the program source and memory.
interface imem_loader_if #(
    parameter int ADDR_W = 12
) ();
    import imem_loader_pkg::*;

    logic                in_load_start;
    logic [ADDR_W:0]     in_load_words;
    logic                in_byte_valid;
    logic [BYTE_W-1:0]   in_byte;
    logic                out_byte_ready;
    logic                out_mem_we;
    logic [ADDR_W-1:0]   out_mem_addr;
    logic [WORD_W-1:0]   out_mem_wdata;
    logic                out_cpu_hold;
    logic                out_load_done;
    logic                out_load_error;
    logic [WORD_W-1:0]   out_checksum;

    modport master (
        output in_load_start, in_load_words, in_byte_valid, in_byte,
        input  out_byte_ready, out_mem_we, out_mem_addr, out_mem_wdata,
               out_cpu_hold, out_load_done, out_load_error, out_checksum
    );

    modport slave (
        input  in_load_start, in_load_words, in_byte_valid, in_byte,
        output out_byte_ready, out_mem_we, out_mem_addr, out_mem_wdata,
               out_cpu_hold, out_load_done, out_load_error, out_checksum
    );

endinterface

// File: rtl/imem_loader_word_assembler.sv
// Shifts accepted bytes MSB-first into a 32-bit word and flags the byte that
// completes it; clear restarts assembly at byte 0.
module word_assembler
    import imem_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              accept,
    input  logic [BYTE_W-1:0] byte_in,
    output logic [WORD_W-1:0] word,
    output logic              word_ready
);

    logic [1:0]        cnt_q, cnt_d;
    logic [WORD_W-1:0] word_q, word_d;

    // Shift register and byte counter next values
    always_comb begin
        cnt_d  = cnt_q;
        word_d = word_q;
        if (clear) begin
            cnt_d  = 2'd0;
            word_d = '0;
        end else if (accept) begin
            cnt_d  = cnt_q + 2'd1;
            word_d = {word_q[WORD_W-BYTE_W-1:0], byte_in};
        end else begin
            cnt_d  = cnt_q;
            word_d = word_q;
        end
    end

    // Assembler state registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q  <= 2'd0;
            word_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            word_q <= word_d;
        end
    end

    assign word       = word_q;
    assign word_ready = accept && !clear && (cnt_q == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: assembles a big-endian byte stream into words,
// writes them from BASE_WORD upward and stalls the CPU for the whole load.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int MEM_WORDS = 4000,
    parameter int ADDR_W    = 12,
    parameter int BASE_WORD = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    imem_loader_if.slave bus
);

    localparam int CHK_W = ADDR_W + 2;

    state_e              state_q, state_d;
    logic [ADDR_W:0]     len_q, len_d;
    logic [ADDR_W:0]     word_cnt_q, word_cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [WORD_W-1:0]   checksum_q, checksum_d;

    logic                byte_ready_s;
    logic                mem_we_s;
    logic [ADDR_W-1:0]   mem_addr_s;
    logic [WORD_W-1:0]   mem_wdata_s;
    logic                cpu_hold_s;
    logic                load_done_s;
    logic                load_error_s;

    logic                start_s;
    logic                accept_s;
    logic                too_long_s;
    logic                last_word_s;
    logic [CHK_W-1:0]    load_end_s;
    logic [ADDR_W:0]     word_cnt_inc_s;
    logic [WORD_W-1:0]   word_s;
    logic                word_ready_s;

    // Wide enough that BASE_WORD + len cannot wrap before the range check
    assign load_end_s     = CHK_W'(BASE_WORD) + {1'b0, bus.in_load_words};
    assign too_long_s     = load_end_s > CHK_W'(MEM_WORDS);
    assign start_s        = (state_q == IDLE) && bus.in_load_start;
    assign accept_s       = bus.in_byte_valid && byte_ready_s;
    assign word_cnt_inc_s = word_cnt_q + (ADDR_W+1)'(1'b1);
    assign last_word_s    = (word_cnt_inc_s == len_q);

    word_assembler u_asm (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (start_s),
        .accept     (accept_s),
        .byte_in    (bus.in_byte),
        .word       (word_s),
        .word_ready (word_ready_s)
    );

    // State, counter and checksum registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            len_q      <= '0;
            word_cnt_q <= '0;
            addr_q     <= '0;
            checksum_q <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            word_cnt_q <= word_cnt_d;
            addr_q     <= addr_d;
            checksum_q <= checksum_d;
        end
    end

    // Next-state selection
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (!bus.in_load_start) begin
                    state_d = IDLE;
                end else if (too_long_s) begin
                    state_d = ERR;
                end else if (bus.in_load_words == '0) begin
                    state_d = DONE;
                end else begin
                    state_d = RECV;
                end
            end
            RECV: begin
                if (word_ready_s) begin
                    state_d = WRITE;
                end else begin
                    state_d = RECV;
                end
            end
            WRITE: begin
                if (last_word_s) begin
                    state_d = DONE;
                end else begin
                    state_d = RECV;
                end
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Length capture, word/address counters and checksum update
    always_comb begin
        len_d      = len_q;
        word_cnt_d = word_cnt_q;
        addr_d     = addr_q;
        checksum_d = checksum_q;
        case (state_q)
            IDLE: begin
                if (bus.in_load_start) begin
                    len_d = bus.in_load_words;
                    if (!too_long_s && (bus.in_load_words != '0)) begin
                        word_cnt_d = '0;
                        addr_d     = ADDR_W'(BASE_WORD);
                        checksum_d = '0;
                    end else begin
                        word_cnt_d = word_cnt_q;
                    end
                end else begin
                    len_d = len_q;
                end
            end
            WRITE: begin
                word_cnt_d = word_cnt_inc_s;
                addr_d     = addr_q + ADDR_W'(1'b1);
                checksum_d = checksum_fold(checksum_q, word_s);
            end
            default: begin
                len_d = len_q;
            end
        endcase
    end

    // Output decode of the current state; memory bus is zero unless writing
    always_comb begin
        byte_ready_s = 1'b0;
        mem_we_s     = 1'b0;
        mem_addr_s   = '0;
        mem_wdata_s  = '0;
        cpu_hold_s   = 1'b0;
        load_done_s  = 1'b0;
        load_error_s = 1'b0;
        case (state_q)
            IDLE: begin
                cpu_hold_s = 1'b0;
            end
            RECV: begin
                byte_ready_s = 1'b1;
                cpu_hold_s   = 1'b1;
            end
            WRITE: begin
                mem_we_s    = 1'b1;
                mem_addr_s  = addr_q;
                mem_wdata_s = word_s;
                cpu_hold_s  = 1'b1;
            end
            DONE: begin
                load_done_s = 1'b1;
                cpu_hold_s  = 1'b1;
            end
            ERR: begin
                load_error_s = 1'b1;
            end
            default: begin
                cpu_hold_s = 1'b0;
            end
        endcase
    end

    assign bus.out_byte_ready = byte_ready_s;
    assign bus.out_mem_we     = mem_we_s;
    assign bus.out_mem_addr   = mem_addr_s;
    assign bus.out_mem_wdata  = mem_wdata_s;
    assign bus.out_cpu_hold   = cpu_hold_s;
    assign bus.out_load_done  = load_done_s;
    assign bus.out_load_error = load_error_s;
    assign bus.out_checksum   = checksum_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: table of load scenarios plus reset and restart
// sequences; expected memory writes go through a scoreboard queue.
module tb_imem_loader;
    import imem_loader_pkg::*;

    localparam int MEM_WORDS = 4000;
    localparam int ADDR_W    = 12;
    localparam int BASE_WORD = 0;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

    imem_loader #(
        .MEM_WORDS (MEM_WORDS),
        .ADDR_W    (ADDR_W),
        .BASE_WORD (BASE_WORD)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    typedef struct {
        int          len;
        int          gap;
        bit          exp_err;
        logic [31:0] w0;
        logic [31:0] w1;
        bit          chk_cs;
        logic [31:0] exp_cs;
        bit          inject;
    } vec_t;

    wr_t               exp_q[$];
    logic [31:0]       mem [MEM_WORDS];
    int                errors = 0;
    int                checks = 0;
    int                wr_cnt = 0;
    int                done_cnt = 0;
    int                err_cnt = 0;
    int                hold_bad = 0;
    bit                expect_hold = 1'b0;
    logic [ADDR_W-1:0] last_addr = '0;
    int                acc = 0;
    bit                exp_we_next = 1'b0;
    vec_t              vecs[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: write timing, scoreboard compare, idle bus, pulse counting
    always @(negedge clk) begin
        wr_t e;
        #2;
        if (!rst_n) begin
            acc         = 0;
            exp_we_next = 1'b0;
        end else begin
            chk("we_timing", 64'(bus.out_mem_we), 64'(exp_we_next));
            if (bus.out_mem_we) begin
                chk("ready_in_write", 64'(bus.out_byte_ready), 64'd0);
                chk("write_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("wr_addr", 64'(bus.out_mem_addr), 64'(e.addr));
                    chk("wr_data", 64'(bus.out_mem_wdata), 64'(e.data));
                end
                if (int'(bus.out_mem_addr) < MEM_WORDS) mem[bus.out_mem_addr] = bus.out_mem_wdata;
                wr_cnt++;
                last_addr = bus.out_mem_addr;
            end else begin
                chk("idle_bus", {20'd0, bus.out_mem_addr, bus.out_mem_wdata}, 64'd0);
            end
            if (bus.out_load_done)  done_cnt++;
            if (bus.out_load_error) err_cnt++;
            if (expect_hold && !bus.out_cpu_hold) hold_bad++;
            exp_we_next = bus.in_byte_valid && bus.out_byte_ready && (acc == 3);
            if (bus.in_byte_valid && bus.out_byte_ready) acc = (acc + 1) % 4;
        end
    end

    // Offer one byte after a gap and hold it until the loader takes it
    task automatic drive_byte(input logic [7:0] b, input int gap);
        int budget;
        bus.in_byte_valid = 1'b0;
        repeat (gap) @(negedge clk);
        bus.in_byte_valid = 1'b1;
        bus.in_byte       = b;
        budget = 0;
        while (!bus.out_byte_ready && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        if (budget >= 50) chk("ready_timeout", 64'(bus.out_byte_ready), 64'd1);
        @(negedge clk);
        bus.in_load_start = 1'b0;
    endtask

    task automatic run_load(input vec_t v, input string tag);
        int          wr0, dn0, er0, budget;
        logic [31:0] w, cs;
        wr0 = wr_cnt; dn0 = done_cnt; er0 = err_cnt; cs = '0;
        hold_bad = 0;
        @(negedge clk);
        bus.in_load_start = 1'b1;
        bus.in_load_words = (ADDR_W+1)'(v.len);
        @(negedge clk);
        bus.in_load_start = 1'b0;
        if (v.exp_err) begin
            chk({tag, "_err_pulse"}, 64'(bus.out_load_error), 64'd1);
            chk({tag, "_err_hold"}, 64'(bus.out_cpu_hold), 64'd0);
            @(negedge clk);
        end else if (v.len == 0) begin
            chk({tag, "_done_pulse"}, 64'(bus.out_load_done), 64'd1);
            chk({tag, "_done_hold"}, 64'(bus.out_cpu_hold), 64'd1);
            @(negedge clk);
        end else begin
            expect_hold = 1'b1;
            for (int i = 0; i < v.len; i++) begin
                w = (i == 0) ? v.w0 : (i == 1) ? v.w1 : $urandom;
                cs = cs ^ w;
                for (int k = 0; k < 4; k++) begin
                    if (k == 3) exp_q.push_back('{addr: ADDR_W'(BASE_WORD + i), data: w});
                    if (v.inject && i == 1 && k == 1) begin
                        bus.in_load_start = 1'b1;
                        bus.in_load_words = (ADDR_W+1)'(7);
                    end
                    drive_byte(w[31-8*k -: 8], v.gap);
                end
            end
            bus.in_byte_valid = 1'b0;
            budget = 0;
            while (!bus.out_load_done && budget < 20) begin
                @(negedge clk);
                budget++;
            end
            chk({tag, "_done_seen"}, 64'(bus.out_load_done), 64'd1);
            chk({tag, "_hold_at_done"}, 64'(bus.out_cpu_hold), 64'd1);
            expect_hold = 1'b0;
            chk({tag, "_hold_through_load"}, 64'(hold_bad), 64'd0);
            chk({tag, "_checksum_model"}, 64'(bus.out_checksum), 64'(cs));
            if (v.chk_cs) chk({tag, "_checksum_const"}, 64'(bus.out_checksum), 64'(v.exp_cs));
            @(negedge clk);
        end
        chk({tag, "_hold_after"}, 64'(bus.out_cpu_hold), 64'd0);
        chk({tag, "_ready_after"}, 64'(bus.out_byte_ready), 64'd0);
        chk({tag, "_done_count"}, 64'(done_cnt - dn0), v.exp_err ? 64'd0 : 64'd1);
        chk({tag, "_err_count"}, 64'(err_cnt - er0), v.exp_err ? 64'd1 : 64'd0);
        chk({tag, "_write_count"}, 64'(wr_cnt - wr0), v.exp_err ? 64'd0 : 64'(v.len));
        if (v.len == MEM_WORDS) chk({tag, "_last_addr"}, 64'(last_addr), 64'(MEM_WORDS - 1));
    endtask

    initial begin
        vec_t        rv;
        int          wr0;
        logic [31:0] w_a;
        bus.in_load_start = 1'b0;
        bus.in_load_words = '0;
        bus.in_byte_valid = 1'b0;
        bus.in_byte       = '0;

        vecs[0] = '{2, 0, 1'b0, 32'h12345678, 32'h9ABCDEF0, 1'b1, 32'h88888888, 1'b0};
        vecs[1] = '{1, 3, 1'b0, 32'hDEADBEEF, 32'h00000000, 1'b1, 32'hDEADBEEF, 1'b0};
        vecs[2] = '{0, 0, 1'b0, 32'h00000000, 32'h00000000, 1'b0, 32'h00000000, 1'b0};
        vecs[3] = '{MEM_WORDS + 1, 0, 1'b1, 32'h00000000, 32'h00000000, 1'b0, 32'h00000000, 1'b0};
        vecs[4] = '{MEM_WORDS, 0, 1'b0, 32'h01020304, 32'hF0E0D0C0, 1'b0, 32'h00000000, 1'b0};
        vecs[5] = '{2, 0, 1'b0, 32'hCAFEF00D, 32'h13579BDF, 1'b1, 32'hD9A96BD2, 1'b1};

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs",
            {bus.out_cpu_hold, bus.out_byte_ready, bus.out_mem_we, bus.out_load_done,
             bus.out_load_error, 27'd0, bus.out_checksum},
            64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            run_load(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset after six bytes of a three-word load
        wr0 = wr_cnt;
        w_a = 32'hA1B2C3D4;
        @(negedge clk);
        bus.in_load_start = 1'b1;
        bus.in_load_words = (ADDR_W+1)'(3);
        @(negedge clk);
        bus.in_load_start = 1'b0;
        exp_q.push_back('{addr: ADDR_W'(BASE_WORD), data: w_a});
        for (int k = 0; k < 4; k++) drive_byte(w_a[31-8*k -: 8], 0);
        drive_byte(8'h55, 0);
        drive_byte(8'h66, 0);
        bus.in_byte_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst_outputs",
            {bus.out_cpu_hold, bus.out_byte_ready, bus.out_mem_we, bus.out_load_done,
             bus.out_load_error, 27'd0, bus.out_checksum},
            64'd0);
        chk("midrst_addr_data", {20'd0, bus.out_mem_addr, bus.out_mem_wdata}, 64'd0);
        chk("midrst_writes", 64'(wr_cnt - wr0), 64'd1);
        chk("midrst_mem0_kept", 64'(mem[BASE_WORD]), 64'(w_a));

        rv = '{2, 0, 1'b0, 32'h0F1E2D3C, 32'h4B5A6978, 1'b1, 32'h44444444, 1'b0};
        run_load(rv, "post_rst");

        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
